// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin credit arbiter.
package wrr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_WEIGHT = 1;

    // Circular successor with an explicit wrap, so N need not be a power of two.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first set bit of elig scanning from ptr upward.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any
);

    int          pos;
    logic [IW-1:0] pos_idx;

    // Scan from the far end back toward ptr so the closest eligible index wins.
    always_comb begin
        win     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (elig[pos_idx]) begin
                win = pos_idx;
            end
        end
    end

    assign any = |elig;

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter: a winner holds the grant for up to weight[i] cycles,
// then the grant rotates; weights are retuned through a simple config write port.
module wrr_credit_arbiter #(
    parameter int N  = 4,
    parameter int CW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  REQ,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [CW-1:0] cfg_weight,
    output logic [N-1:0]  GNT,
    output logic [IW-1:0] GNT_ID,
    output logic          GNT_VALID
);

    import wrr_pkg::*;

    logic [CW-1:0] weight [N];

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  gnt;
    logic [N-1:0]  gnt_next;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_next;
    logic [CW-1:0] credit;
    logic [CW-1:0] credit_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;

    logic [N-1:0]  elig;
    logic [IW-1:0] win;
    logic          any;
    logic          done;
    logic          open;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = REQ[i] & (weight[i] != '0);
        end
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .win  (win),
        .any  (any)
    );

    // The owner's tenure ends on its last credited cycle, when it stops asking, or when disabled.
    assign done = (state == GRANT) &&
                  (!REQ[owner] || (credit == CW'(1)) || (weight[owner] == '0));
    assign open = (state == IDLE) || done;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                weight[i] <= CW'(DEFAULT_WEIGHT);
            end
        end else if (cfg_we && (int'(cfg_idx) < N)) begin
            weight[cfg_idx] <= cfg_weight;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any) state_next = GRANT;
            GRANT:   if (done && !any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Because ptr sits just past the owner, the owner is only re-picked when nobody else is eligible.
    always_comb begin
        gnt_next    = gnt;
        owner_next  = owner;
        credit_next = credit;
        ptr_next    = ptr;
        if (open && any) begin
            for (int i = 0; i < N; i++) begin
                gnt_next[i] = (IW'(i) == win);
            end
            owner_next  = win;
            credit_next = weight[win];
            ptr_next    = IW'(next_idx(int'(win), N));
        end else if (open) begin
            gnt_next    = '0;
            owner_next  = '0;
            credit_next = '0;
        end else if (credit != '0) begin
            credit_next = credit - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            owner  <= '0;
            credit <= '0;
            ptr    <= '0;
        end else begin
            gnt    <= gnt_next;
            owner  <= owner_next;
            credit <= credit_next;
            ptr    <= ptr_next;
        end
    end

    assign GNT       = gnt;
    assign GNT_ID    = owner;
    assign GNT_VALID = |gnt;

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Bench for wrr_credit_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a tenure-counting reference model.
module tb_wrr_credit_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  REQ;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [CW-1:0] cfg_weight;
    logic [N-1:0]  GNT;
    logic [IW-1:0] GNT_ID;
    logic          GNT_VALID;

    int n_cmp  = 0;
    int n_fail = 0;

    logic last_rst;

    int m_owner;
    int m_used;
    int m_budget;
    int m_ptr;
    int m_wt [N];

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          we;
        logic [IW-1:0] idx;
        logic [CW-1:0] w;
        logic [N-1:0]  exp_gnt;
    } vec_t;

    vec_t vecs[$];

    wrr_credit_arbiter #(
        .N  (N),
        .CW (CW),
        .IW (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .REQ        (REQ),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .GNT        (GNT),
        .GNT_ID     (GNT_ID),
        .GNT_VALID  (GNT_VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit bitAt(input logic [N-1:0] v, input int i);
        logic [IW-1:0] k;
        k = i[IW-1:0];
        return v[k];
    endfunction

    // Model tracks cycles used in the current tenure against the budget fixed when it began.
    task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic we,
                             input logic [IW-1:0] idx, input logic [CW-1:0] w);
        int pick;
        int j;
        if (r) begin
            m_owner  = -1;
            m_used   = 0;
            m_budget = 0;
            m_ptr    = 0;
            foreach (m_wt[i]) m_wt[i] = 1;
            return;
        end
        if (m_owner >= 0 && bitAt(rq, m_owner) && m_wt[m_owner] != 0 && m_used < m_budget) begin
            m_used = m_used + 1;
        end else begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (pick < 0 && bitAt(rq, j) && m_wt[j] != 0) pick = j;
            end
            m_owner = pick;
            if (pick >= 0) begin
                m_budget = m_wt[pick];
                m_used   = 1;
                m_ptr    = (pick + 1) % N;
            end
        end
        if (we && int'(idx) < N) m_wt[idx] = int'(w);
    endtask

    function automatic logic [N-1:0] modelGnt();
        if (m_owner < 0) return '0;
        return N'(1) << m_owner;
    endfunction

    task automatic addVec(input logic r, input logic [N-1:0] rq, input logic we,
                          input logic [IW-1:0] idx, input logic [CW-1:0] w,
                          input logic [N-1:0] exp_gnt);
        vec_t v;
        v.rst = r; v.req = rq; v.we = we; v.idx = idx; v.w = w; v.exp_gnt = exp_gnt;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic we,
                                 input logic [IW-1:0] idx, input logic [CW-1:0] w);
        rst        = r;
        REQ        = rq;
        cfg_we     = we;
        cfg_idx    = idx;
        cfg_weight = w;
        @(posedge clk);
        modelStep(r, rq, we, idx, w);
        last_rst = r;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] exp_gnt);
        logic [IW-1:0] exp_id;
        logic          exp_valid;
        exp_id = '0;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) exp_id = IW'(i);
        exp_valid = |exp_gnt;
        n_cmp++;
        if (GNT !== exp_gnt) begin
            n_fail++;
            $display("[TB] FAIL %s GNT: got %b want %b at %0t", name, GNT, exp_gnt, $time);
        end
        n_cmp++;
        if (GNT_VALID !== exp_valid) begin
            n_fail++;
            $display("[TB] FAIL %s GNT_VALID: got %b want %b at %0t", name, GNT_VALID, exp_valid, $time);
        end
        if (exp_valid || last_rst) begin
            n_cmp++;
            if (GNT_ID !== exp_id) begin
                n_fail++;
                $display("[TB] FAIL %s GNT_ID: got %0d want %0d at %0t", name, GNT_ID, exp_id, $time);
            end
        end
    endtask

    task automatic stepCheck(input string name, input logic [N-1:0] rq, input logic we,
                             input logic [IW-1:0] idx, input logic [CW-1:0] w,
                             input logic [N-1:0] exp_gnt);
        applyStimulus(1'b0, rq, we, idx, w);
        checkOutput(name, exp_gnt);
    endtask

    initial begin
        logic [N-1:0]  rq;
        logic          r;
        logic          we;
        logic [IW-1:0] idx;
        logic [CW-1:0] w;

        rst = 1'b1; REQ = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        last_rst = 1'b0;
        modelStep(1'b1, '0, 1'b0, '0, '0);

        // Default weights: plain single-cycle rotation.
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000);
        addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0001);
        addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0010);
        addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0100);
        addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b1000);
        addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0001);
        // Weights {3,1,2,1} loaded from a fresh reset so rotation starts at index 0.
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000);
        addVec(1'b0, 4'b0000, 1'b1, 2'd0, 4'd3, 4'b0000);
        addVec(1'b0, 4'b0000, 1'b1, 2'd2, 4'd2, 4'b0000);
        for (int rep = 0; rep < 2; rep++) begin
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0001);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0001);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0001);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0010);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0100);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b0100);
            addVec(1'b0, 4'b1111, 1'b0, 2'd0, 4'd0, 4'b1000);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].idx, vecs[i].w);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt);
        end

        // Early release with no bubble.
        stepCheck("early_cfg",  4'b0000, 1'b1, 2'd1, 4'd4, 4'b0000);
        stepCheck("early_g1",   4'b0010, 1'b0, 2'd0, 4'd0, 4'b0010);
        stepCheck("early_g2",   4'b0010, 1'b0, 2'd0, 4'd0, 4'b0010);
        stepCheck("early_move", 4'b1000, 1'b0, 2'd0, 4'd0, 4'b1000);

        // Disabling the current owner.
        stepCheck("dis_cfg",     4'b0000, 1'b1, 2'd2, 4'd4, 4'b0000);
        stepCheck("dis_grant",   4'b0100, 1'b0, 2'd0, 4'd0, 4'b0100);
        stepCheck("dis_write0",  4'b0100, 1'b1, 2'd2, 4'd0, 4'b0100);
        stepCheck("dis_release", 4'b0100, 1'b0, 2'd0, 4'd0, 4'b0000);
        for (int c = 0; c < 5; c++) stepCheck($sformatf("dis_only0_%0d", c), 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0001);

        // Sole requester keeps the grant across credit reloads.
        stepCheck("sole_cfg", 4'b0000, 1'b1, 2'd3, 4'd2, 4'b0000);
        for (int c = 0; c < 6; c++) stepCheck($sformatf("sole_%0d", c), 4'b1000, 1'b0, 2'd0, 4'd0, 4'b1000);

        // Reset in the middle of a weight-3 tenure.
        stepCheck("rstmid_idle", 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000);
        stepCheck("rstmid_g1",   4'b0001, 1'b0, 2'd0, 4'd0, 4'b0001);
        stepCheck("rstmid_g2",   4'b0001, 1'b0, 2'd0, 4'd0, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0, 4'd0);
        checkOutput("rstmid_drop", 4'b0000);
        stepCheck("rstmid_first", 4'b1010, 1'b0, 2'd0, 4'd0, 4'b0010);
        stepCheck("rstmid_w1",    4'b1010, 1'b0, 2'd0, 4'd0, 4'b1000);
        stepCheck("rstmid_back",  4'b1010, 1'b0, 2'd0, 4'd0, 4'b0010);

        // Randomized traffic against the reference model.
        applyStimulus(1'b1, '0, 1'b0, '0, '0);
        checkOutput("rand_reset", modelGnt());
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
            r   = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 5) == 0);
            idx = IW'($urandom_range(0, 3));
            w   = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 3));
            applyStimulus(r, rq, we, idx, w);
            checkOutput($sformatf("rand%0d", c), modelGnt());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
